// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - shared peripheral bus bundle for the UART TX block
interface uart_tx_fifo_if;
  logic [31:0] MADDR;
  wire  [31:0] MDATA;
  logic        MEN;
  logic        MRW;
  wire         MWAIT;

  modport master (
    output MADDR,
    output MEN,
    output MRW,
    inout  MDATA,
    input  MWAIT
  );

  modport slave (
    input  MADDR,
    input  MEN,
    input  MRW,
    inout  MDATA,
    output MWAIT
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - memory-mapped 8N1 UART transmitter with TX FIFO and idle interrupt
module uart_tx_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0040,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd40
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   bus,
  output logic            tx,
  output logic            irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          sel;
  logic          wr_en;
  logic          rd_en;
  logic [1:0]    reg_addr;
  logic          push_req;
  logic          flush_req;
  logic          ovf_clr;
  logic          pop;
  logic          do_push;
  logic          full;
  logic          empty;
  logic          busy;
  logic          bit_end;
  logic          start_frame;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    count8;
  logic [7:0]    head;
  logic          overflow;
  logic [7:0]    last_byte;
  logic [15:0]   div_reg;
  logic          tx_en;
  logic          irq_en;

  logic [1:0]    state;
  logic [15:0]   div_lat;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;

  logic [31:0]   status;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign sel       = bus.MEN && (bus.MADDR[31:4] == BASE_ADDR[31:4]);
  assign wr_en     = sel && bus.MRW;
  assign rd_en     = sel && !bus.MRW;
  assign reg_addr  = bus.MADDR[3:2];
  assign push_req  = wr_en && (reg_addr == 2'b00);
  assign ovf_clr   = wr_en && (reg_addr == 2'b01) && bus.MDATA[3];
  assign flush_req = wr_en && (reg_addr == 2'b11) && bus.MDATA[2];

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A frame starts (and pops the head) from IDLE, or straight out of the last STOP cycle.
  assign bit_end     = (bit_cnt == div_lat);
  assign start_frame = tx_en && !empty &&
                       ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign pop         = start_frame;
  // A push into a full FIFO still lands when the engine frees a slot on the same edge.
  assign do_push     = push_req && (!full || pop);

  assign busy   = !empty || (state != S_IDLE);
  assign count8 = 8'(count);
  assign status = {16'd0, count8, 4'd0, overflow, empty, full, busy};

  assign unused_bits = ^{bus.MADDR[1:0], bus.MDATA[31:16]};

  // FIFO storage: written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.MDATA[7:0];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the last written DATA byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_byte <= 8'd0;
    end else begin
      if (push_req) begin
        last_byte <= bus.MDATA[7:0];
      end
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (flush_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(do_push) - CW'(pop);
      end
    end
  end

  // Software-visible configuration: baud divisor and control bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= DIV_RESET;
      tx_en   <= 1'b1;
      irq_en  <= 1'b0;
    end else begin
      if (wr_en && (reg_addr == 2'b10)) begin
        div_reg <= bus.MDATA[15:0];
      end
      if (wr_en && (reg_addr == 2'b11)) begin
        tx_en  <= bus.MDATA[0];
        irq_en <= bus.MDATA[1];
      end
    end
  end

  // Transmit engine: start bit, eight data bits LSB first, stop bit, each DIV_latched+1 clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      div_lat <= 16'd0;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shifter <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_frame) begin
            shifter <= head;
            div_lat <= div_reg;
            bit_cnt <= 16'd0;
            state   <= S_START;
            tx      <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            state   <= S_DATA;
            tx      <= shifter[0];
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shifter <= {1'b0, shifter[7:1]};
              tx      <= shifter[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            if (start_frame) begin
              shifter <= head;
              div_lat <= div_reg;
              bit_cnt <= 16'd0;
              state   <= S_START;
              tx      <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Idle interrupt, registered so it follows the condition by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && empty && (state == S_IDLE);
    end
  end

  // Combinational read mux.
  always_comb begin
    rdata = 32'd0;
    case (reg_addr)
      2'b00:   rdata = {24'd0, last_byte};
      2'b01:   rdata = status;
      2'b10:   rdata = {16'd0, div_reg};
      default: rdata = {30'd0, irq_en, tx_en};
    endcase
  end

  assign bus.MDATA = rd_en ? rdata : 32'bz;
  assign bus.MWAIT = sel ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0040;
  localparam int          INF   = 1 << 30;
  localparam int          MAXC  = 40000;
  localparam logic [3:0]  A_DATA = 4'h0;
  localparam logic [3:0]  A_STAT = 4'h4;
  localparam logic [3:0]  A_DIV  = 4'h8;
  localparam logic [3:0]  A_CTRL = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx;
  logic        irq;
  logic [31:0] mdata_drv;
  logic        mdata_oe;

  uart_tx_fifo_if bus ();
  assign bus.MDATA = mdata_oe ? mdata_drv : 32'bz;

  uart_tx_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each accepted byte becomes a frame whose start edge is
  // max(push+1, end of previous frame, enable+1); the tx waveform is painted from that.
  bit         exp_tx [MAXC];
  int         m_n;
  logic [7:0] m_byte [512];
  int         m_push [512];
  int         m_start[512];
  int         m_len  [512];
  bit         m_valid[512];
  int         m_e_last;
  bit         m_en;
  int         m_en_edge;
  bit         m_ovf;
  bit         m_irq_en;
  bit         m_irq_prev;
  int         m_irq_edge;
  int         dw_n;
  int         dw_edge[256];
  int         dw_val [256];

  bit mon_en = 1'b0;
  int mism = 0;
  int first_bad = 0;

  always @(negedge clk) begin
    if (mon_en && cyc < MAXC) begin
      if (tx !== exp_tx[cyc]) begin
        if (mism == 0) first_bad = cyc;
        mism++;
      end
    end
  end

  function automatic int div_at(input int s);
    int d = 40;
    for (int i = 0; i < dw_n; i++) if (dw_edge[i] < s) d = dw_val[i];
    return d;
  endfunction

  function automatic int count_at(input int c);
    int n = 0;
    for (int i = 0; i < m_n; i++)
      if (m_valid[i] && m_push[i] <= c && m_start[i] > c) n++;
    return n;
  endfunction

  function automatic bit active_at(input int c);
    for (int i = 0; i < m_n; i++)
      if (m_valid[i] && m_start[i] != INF && m_start[i] <= c && c < m_start[i] + m_len[i])
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_status(input int c);
    int n;
    logic [7:0] n8;
    n  = count_at(c);
    n8 = 8'(n);
    return {16'd0, n8, 4'd0, m_ovf, (n == 0), (n == DEPTH), (n != 0) || active_at(c)};
  endfunction

  function automatic bit m_irq(input int c);
    bit en;
    en = (c - 1 >= m_irq_edge) ? m_irq_en : m_irq_prev;
    return en && (count_at(c - 1) == 0) && !active_at(c - 1);
  endfunction

  task automatic sched(input int i);
    int s, d, len, j;
    s = m_push[i] + 1;
    if (m_e_last > s) s = m_e_last;
    if (m_en_edge + 1 > s) s = m_en_edge + 1;
    d   = div_at(s);
    len = 10 * (d + 1);
    for (int c = s; c < s + len; c++) begin
      j = (c - s) / (d + 1);
      exp_tx[c] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : m_byte[i][j-1];
    end
    m_start[i] = s;
    m_len[i]   = len;
    m_e_last   = s + len;
  endtask

  task automatic model_reset(input int r);
    for (int c = r; c < MAXC; c++) exp_tx[c] = 1'b1;
    m_n = 0; m_e_last = 0; m_en = 1'b1; m_en_edge = r; m_ovf = 1'b0;
    m_irq_en = 1'b0; m_irq_prev = 1'b0; m_irq_edge = r;
    dw_n = 1; dw_edge[0] = -1; dw_val[0] = 40;
  endtask

  task automatic model_push(input int n, input logic [7:0] b);
    bit pop_now = 1'b0;
    for (int i = 0; i < m_n; i++) if (m_valid[i] && m_start[i] == n) pop_now = 1'b1;
    if (count_at(n - 1) >= DEPTH && !pop_now) begin
      m_ovf = 1'b1;
    end else begin
      m_byte[m_n] = b; m_push[m_n] = n; m_start[m_n] = INF; m_len[m_n] = 0; m_valid[m_n] = 1'b1;
      m_n++;
      if (m_en) sched(m_n - 1);
    end
  endtask

  task automatic model_flush(input int w);
    for (int i = 0; i < m_n; i++) begin
      if (m_valid[i] && m_start[i] > w) begin
        if (m_start[i] != INF)
          for (int c = m_start[i]; c < m_start[i] + m_len[i]; c++) exp_tx[c] = 1'b1;
        m_valid[i] = 1'b0;
      end
    end
    m_e_last = 0;
    for (int i = 0; i < m_n; i++)
      if (m_valid[i] && m_start[i] != INF && m_start[i] + m_len[i] > m_e_last)
        m_e_last = m_start[i] + m_len[i];
  endtask

  task automatic model_write(input int n, input logic [3:0] off, input logic [31:0] d);
    case (off)
      A_DATA: model_push(n, d[7:0]);
      A_STAT: if (d[3]) m_ovf = 1'b0;
      A_DIV: begin dw_edge[dw_n] = n; dw_val[dw_n] = int'(d[15:0]); dw_n++; end
      default: begin
        if (d[2]) model_flush(n);
        m_irq_prev = m_irq_en; m_irq_en = d[1]; m_irq_edge = n;
        if (d[0] && !m_en) begin
          m_en = 1'b1; m_en_edge = n;
          for (int i = 0; i < m_n; i++) if (m_valid[i] && m_start[i] == INF) sched(i);
        end else if (!d[0]) begin
          m_en = 1'b0;
        end
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wave_check(input string name);
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL %s: %0d tx cycles differ from model (expected 0), first at cycle %0d",
               name, mism, first_bad);
    end
    mism = 0;
  endtask

  task automatic bus_wr(input logic [3:0] off, input logic [31:0] d);
    bus.MADDR = BASE | 32'(off);
    bus.MEN   = 1'b1;
    bus.MRW   = 1'b1;
    mdata_drv = d;
    mdata_oe  = 1'b1;
    model_write(cyc + 1, off, d);
    @(negedge clk);
    bus.MEN  = 1'b0;
    bus.MRW  = 1'b0;
    mdata_oe = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] off, output logic [31:0] d);
    bus.MADDR = BASE | 32'(off);
    bus.MEN   = 1'b1;
    bus.MRW   = 1'b0;
    mdata_oe  = 1'b0;
    #1;
    d = bus.MDATA;
    check("mwait_sel", {31'd0, bus.MWAIT}, 32'd0);
    bus.MEN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [39:0] cap40, exp40;
    logic [19:0] dec, exp20;
    logic [79:0] cap80;
    logic [9:0]  f1, f2;
    int          w;

    tbl[0]  = '{1'b0, A_DATA, 32'h0,         32'h0000_0000, "rst_data"};
    tbl[1]  = '{1'b0, A_STAT, 32'h0,         32'h0000_0004, "rst_status"};
    tbl[2]  = '{1'b0, A_DIV,  32'h0,         32'h0000_0028, "rst_div"};
    tbl[3]  = '{1'b0, A_CTRL, 32'h0,         32'h0000_0001, "rst_ctrl"};
    tbl[4]  = '{1'b1, A_DIV,  32'hABCD_1234, 32'h0,         "wr_div"};
    tbl[5]  = '{1'b0, A_DIV,  32'h0,         32'h0000_1234, "div_16bit"};
    tbl[6]  = '{1'b1, A_CTRL, 32'hFFFF_FFFF, 32'h0,         "wr_ctrl_all"};
    tbl[7]  = '{1'b0, A_CTRL, 32'h0,         32'h0000_0003, "ctrl_flush_reads0"};
    tbl[8]  = '{1'b1, A_STAT, 32'hFFFF_FFFF, 32'h0,         "wr_status"};
    tbl[9]  = '{1'b0, A_STAT, 32'h0,         32'h0000_0004, "status_ro"};
    tbl[10] = '{1'b1, A_CTRL, 32'h0000_0001, 32'h0,         "wr_ctrl"};
    tbl[11] = '{1'b1, A_DIV,  32'h0000_0003, 32'h0,         "wr_div3"};
    tbl[12] = '{1'b0, A_DIV,  32'h0,         32'h0000_0003, "div3"};
    tbl[13] = '{1'b0, A_CTRL, 32'h0,         32'h0000_0001, "ctrl1"};

    for (int c = 0; c < MAXC; c++) exp_tx[c] = 1'b1;
    rst = 1'b1; bus.MADDR = 32'h0; bus.MEN = 1'b0; bus.MRW = 1'b0;
    mdata_drv = 32'h0; mdata_oe = 1'b0;
    idle(3);
    model_reset(cyc);
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        bus_wr(tbl[i].off, tbl[i].wdata);
      end else begin
        bus_rd(tbl[i].off, rd);
        check(tbl[i].name, rd, tbl[i].exp);
      end
    end
    idle(2);

    // 0x55 at DIV=3: alternating bits, 4 clocks each, starting the cycle after the write edge.
    bus_wr(A_DATA, 32'h55);
    check("t1_latency_hi", {31'd0, tx}, 32'd1);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      cap40[j] = tx;
      exp40[j] = ((j / 4) % 2) == 1;
    end
    check("t1_wave", cap40[31:0], exp40[31:0]);
    check("t1_wave_hi", {24'd0, cap40[39:32]}, {24'd0, exp40[39:32]});
    idle(2);
    bus_rd(A_STAT, rd);
    check("t1_status", rd, 32'h0000_0004);
    bus_rd(A_DATA, rd);
    check("t1_last_byte", rd, 32'h0000_0055);
    wave_check("t1_model");

    // Disabled engine, 17 pushes into 16 slots, then drain in order.
    bus_wr(A_CTRL, 32'h0);
    for (int i = 0; i < 17; i++) bus_wr(A_DATA, 32'(i));
    bus_rd(A_STAT, rd);
    check("t2_full_status", rd, 32'h0000_100B);
    check("t2_full_model", rd, m_status(cyc));
    bus_wr(A_CTRL, 32'h1);
    idle(16 * 40 + 5);
    wave_check("t2_drain");
    bus_rd(A_STAT, rd);
    check("t2_ovf_sticky", rd, 32'h0000_000C);
    bus_wr(A_STAT, 32'h8);
    bus_rd(A_STAT, rd);
    check("t2_ovf_clear", rd, 32'h0000_0004);

    // Back-to-back frames with no idle gap.
    bus_wr(A_DATA, 32'hA5);
    bus_wr(A_DATA, 32'h3C);
    for (int j = 0; j < 80; j++) begin
      cap80[j] = tx;
      @(negedge clk);
    end
    f1 = {1'b1, 8'hA5, 1'b0};
    f2 = {1'b1, 8'h3C, 1'b0};
    exp20 = {f2, f1};
    for (int k = 0; k < 20; k++) dec[k] = cap80[4 * k + 2];
    check("t3_decode", {12'd0, dec}, {12'd0, exp20});
    idle(5);
    wave_check("t3_model");

    // DIV change mid-frame only affects the next frame.
    bus_wr(A_DATA, 32'hFF);
    idle(9);
    bus_wr(A_DIV, 32'h7);
    bus_wr(A_DATA, 32'h00);
    idle(101);
    check("t4_last_data_bit", {31'd0, tx}, 32'd0);
    @(negedge clk);
    check("t4_stop_bit", {31'd0, tx}, 32'd1);
    idle(20);
    wave_check("t4_model");

    // Reset in the middle of a data bit aborts everything.
    for (int i = 0; i < 4; i++) bus_wr(A_DATA, 32'hC0 + 32'(i));
    idle(14);
    rst = 1'b1;
    model_reset(cyc + 1);
    @(negedge clk);
    rst = 1'b0;
    check("t5_tx_after_rst", {31'd0, tx}, 32'd1);
    bus_rd(A_STAT, rd);
    check("t5_status", rd, 32'h0000_0004);
    bus_rd(A_DIV, rd);
    check("t5_div", rd, 32'h0000_0028);
    bus_rd(A_DATA, rd);
    check("t5_last_byte", rd, 32'h0000_0000);
    idle(450);
    wave_check("t5_no_frames");

    // Idle interrupt timing and flush keeping only the frame in flight.
    bus_wr(A_DIV, 32'h3);
    bus_wr(A_CTRL, 32'h3);
    idle(2);
    check("t6_irq_idle", {31'd0, irq}, 32'd1);
    bus_wr(A_DATA, 32'h81);
    check("t6_irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("t6_irq_drop", {31'd0, irq}, 32'd0);
    check("t6_irq_model", {31'd0, irq}, {31'd0, m_irq(cyc)});
    idle(40);
    check("t6_irq_stop", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("t6_irq_back", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 4; i++) bus_wr(A_DATA, 32'h11 * 32'(i + 1));
    bus_wr(A_CTRL, 32'h7);
    idle(60);
    bus_rd(A_STAT, rd);
    check("t6_flush_status", rd, 32'h0000_0004);
    check("t6_irq_end", {31'd0, irq}, {31'd0, m_irq(cyc)});
    wave_check("t6_flush_wave");
    bus_wr(A_CTRL, 32'h1);

    // Random pushes against the frame-schedule model, including overflow.
    for (int seg = 0; seg < 3; seg++) begin
      bus_wr(A_DIV, 32'($urandom_range(0, 3)));
      for (int k = 0; k < 40; k++) begin
        idle($urandom_range(0, 4));
        bus_wr(A_DATA, 32'($urandom_range(0, 255)));
        bus_rd(A_STAT, rd);
        check("rand_status", rd, m_status(cyc));
      end
      w = m_e_last - cyc + 3;
      if (w > 0) idle(w);
      bus_rd(A_STAT, rd);
      check("rand_drained", rd, m_status(cyc));
      wave_check("rand_wave");
      bus_wr(A_STAT, 32'h8);
      idle(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
